rpn_lan_rx_window: RTL and testbench

- Parametrised successor of the reliable-LAN receive block.
- Sits between the Network Bridge RX stream and the Control module; the KnownIP TX stream carries replies.
- Keeps an internal per-sender sequence table; no external BRAM.
- Over the previous generation it adds:
  - NACK on sequence gaps.
  - Independent, parallel ctrl and ACK handshakes.
  - Out-of-range sender rejection.
  - A table clear input.
  - Saturating statistics counters.

---
 rtl/rpn_lan_rx_window.sv | 228 ++++++++++++++++++++++
 tb/tb_rpn_lan_rx_window.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_lan_rx_window.sv
// rpn_lan_rx_window: reliable-LAN receive stage with a per-sender sequence table.
// Accepts single-beat messages from the Network Bridge, checks the sequence number
// against the sender's table entry, forwards in-order DATA payloads to Control and
// answers with ACK / NACK / SEQ_REPLY on the KnownIP stream.
// Ports:
//   i_clk, i_ap_rst_n       clock, asynchronous active-low reset
//   i_node_id               own id, inserted into replies
//   i_KIP_port_number       src/dest port placed in the reply tuser
//   i_table_clear           one-cycle pulse, sets every table entry to all-ones
//   from_nb_*               RX AXI-Stream (single-beat messages)
//   to_ctrl_*               payload delivery AXI-Stream
//   to_nb_KIP_*             reply AXI-Stream
//   o_cnt_dup/gap/bad       saturating statistics counters
module rpn_lan_rx_window #(
   parameter int unsigned NUM_NODES        = 16,
   parameter int unsigned NODE_ID_WIDTH    = 4,
   parameter int unsigned SEQ_WIDTH        = 16,
   parameter int unsigned AXIS_DATA_WIDTH  = 512,
   parameter int unsigned AXIS_TID_WIDTH   = 8,
   parameter int unsigned AXIS_TUSER_WIDTH = 32,
   parameter int unsigned MSG_TYPE_WIDTH   = 8,
   parameter int unsigned NODE_ID_OFFSET   = 8,
   parameter int unsigned SEQ_OFFSET       = 16,
   parameter int unsigned DATA_OFFSET      = 64,
   parameter int unsigned DATA_WIDTH       = 256,
   parameter int unsigned TYPE_DATA        = 1,
   parameter int unsigned TYPE_ACK         = 2,
   parameter int unsigned TYPE_SEQ_CHECK   = 3,
   parameter int unsigned TYPE_SEQ_REPLY   = 4,
   parameter int unsigned TYPE_NACK        = 5,
   parameter int unsigned CNT_WIDTH        = 16
) (
   input  logic                          i_clk,
   input  logic                          i_ap_rst_n,
   input  logic [NODE_ID_WIDTH-1:0]      i_node_id,
   input  logic [15:0]                   i_KIP_port_number,
   input  logic                          i_table_clear,
   input  logic                          from_nb_tvalid,
   output logic                          from_nb_tready,
   input  logic                          from_nb_tlast,
   input  logic [AXIS_DATA_WIDTH-1:0]    from_nb_tdata,
   input  logic [AXIS_DATA_WIDTH/8-1:0]  from_nb_tkeep,
   input  logic [AXIS_TID_WIDTH-1:0]     from_nb_tid,
   input  logic [AXIS_TID_WIDTH-1:0]     from_nb_tdest,
   input  logic [AXIS_TUSER_WIDTH-1:0]   from_nb_tuser,
   output logic                          to_ctrl_tvalid,
   input  logic                          to_ctrl_tready,
   output logic                          to_ctrl_tlast,
   output logic [AXIS_DATA_WIDTH-1:0]    to_ctrl_tdata,
   output logic [AXIS_DATA_WIDTH/8-1:0]  to_ctrl_tkeep,
   output logic [AXIS_TID_WIDTH-1:0]     to_ctrl_tid,
   output logic [AXIS_TID_WIDTH-1:0]     to_ctrl_tdest,
   output logic [AXIS_TUSER_WIDTH-1:0]   to_ctrl_tuser,
   output logic                          to_nb_KIP_tvalid,
   input  logic                          to_nb_KIP_tready,
   output logic                          to_nb_KIP_tlast,
   output logic [AXIS_DATA_WIDTH-1:0]    to_nb_KIP_tdata,
   output logic [AXIS_DATA_WIDTH/8-1:0]  to_nb_KIP_tkeep,
   output logic [63:0]                   to_nb_KIP_tuser,
   output logic [CNT_WIDTH-1:0]          o_cnt_dup,
   output logic [CNT_WIDTH-1:0]          o_cnt_gap,
   output logic [CNT_WIDTH-1:0]          o_cnt_bad
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_EVAL    = 2'd1;
   localparam logic [1:0] S_DELIVER = 2'd2;
   localparam logic [1:0] S_REPLY   = 2'd3;
   localparam int unsigned IDX_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

   logic [1:0]                   state_q, state_d;
   logic [MSG_TYPE_WIDTH-1:0]    type_q;
   logic [NODE_ID_WIDTH-1:0]     id_q;
   logic [SEQ_WIDTH-1:0]         seq_q;
   logic [DATA_WIDTH-1:0]        payload_q;
   logic [AXIS_DATA_WIDTH/8-1:0] tkeep_q;
   logic [AXIS_TID_WIDTH-1:0]    tid_q, tdest_q;
   logic [AXIS_TUSER_WIDTH-1:0]  tuser_q;
   logic                         ctrl_v_q, ctrl_v_d, kip_v_q, kip_v_d;
   logic [MSG_TYPE_WIDTH-1:0]    rtype_q, rtype_d;
   logic [SEQ_WIDTH-1:0]         rseq_q, rseq_d;
   logic [CNT_WIDTH-1:0]         cnt_dup_q, cnt_gap_q, cnt_bad_q;
   logic                         inc_dup, inc_gap, inc_bad, tbl_we;
   logic [SEQ_WIDTH-1:0]         table_q [NUM_NODES];
   logic [IDX_W-1:0]             idx;
   logic                         id_ok;
   logic [SEQ_WIDTH-1:0]         last_seq, exp_seq;
   logic                         rx_fire;
   logic                         unused_ok;

   assign rx_fire  = (state_q == S_IDLE) && from_nb_tvalid;
   assign idx      = id_q[IDX_W-1:0];
   // Widened so the range check stays meaningful whatever the id width.
   assign id_ok    = 32'(id_q) < NUM_NODES;
   assign last_seq = id_ok ? table_q[idx] : '1;
   assign exp_seq  = last_seq + SEQ_WIDTH'(1);

   always_comb begin
      state_d = state_q;
      ctrl_v_d = ctrl_v_q;
      kip_v_d = kip_v_q;
      rtype_d = rtype_q;
      rseq_d = rseq_q;
      inc_dup = 1'b0;
      inc_gap = 1'b0;
      inc_bad = 1'b0;
      tbl_we = 1'b0;
      case (state_q)
         S_IDLE: if (from_nb_tvalid) state_d = S_EVAL;
         S_EVAL: begin
            state_d = S_IDLE;
            if (!id_ok) begin
               inc_bad = 1'b1;
            end else if (type_q == MSG_TYPE_WIDTH'(TYPE_SEQ_CHECK)) begin
               rtype_d = MSG_TYPE_WIDTH'(TYPE_SEQ_REPLY);
               rseq_d = last_seq;
               kip_v_d = 1'b1;
               state_d = S_REPLY;
            end else if (type_q == MSG_TYPE_WIDTH'(TYPE_DATA)) begin
               kip_v_d = 1'b1;
               rtype_d = MSG_TYPE_WIDTH'(TYPE_ACK);
               rseq_d = seq_q;
               state_d = S_REPLY;
               if (seq_q == exp_seq) begin
                  tbl_we = 1'b1;
                  ctrl_v_d = 1'b1;
                  state_d = S_DELIVER;
               end else if (seq_q == last_seq) begin
                  inc_dup = 1'b1;
               end else begin
                  rtype_d = MSG_TYPE_WIDTH'(TYPE_NACK);
                  rseq_d = exp_seq;
                  inc_gap = 1'b1;
               end
            end else begin
               inc_bad = 1'b1;
            end
         end
         S_DELIVER: begin
            // Each side retires on its own handshake; leave once both are done.
            if (to_ctrl_tready) ctrl_v_d = 1'b0;
            if (to_nb_KIP_tready) kip_v_d = 1'b0;
            if (!ctrl_v_d && !kip_v_d) state_d = S_IDLE;
         end
         S_REPLY: begin
            if (to_nb_KIP_tready) begin
               kip_v_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
      if (!i_ap_rst_n) begin
         state_q <= S_IDLE;
         type_q <= '0;
         id_q <= '0;
         seq_q <= '0;
         payload_q <= '0;
         tkeep_q <= '0;
         tid_q <= '0;
         tdest_q <= '0;
         tuser_q <= '0;
         ctrl_v_q <= 1'b0;
         kip_v_q <= 1'b0;
         rtype_q <= '0;
         rseq_q <= '0;
         cnt_dup_q <= '0;
         cnt_gap_q <= '0;
         cnt_bad_q <= '0;
         for (int unsigned i = 0; i < NUM_NODES; i++) table_q[i] <= '1;
      end else begin
         state_q <= state_d;
         ctrl_v_q <= ctrl_v_d;
         kip_v_q <= kip_v_d;
         rtype_q <= rtype_d;
         rseq_q <= rseq_d;
         if (rx_fire) begin
            type_q <= from_nb_tdata[MSG_TYPE_WIDTH-1:0];
            id_q <= from_nb_tdata[NODE_ID_OFFSET +: NODE_ID_WIDTH];
            seq_q <= from_nb_tdata[SEQ_OFFSET +: SEQ_WIDTH];
            payload_q <= from_nb_tdata[DATA_OFFSET +: DATA_WIDTH];
            tkeep_q <= from_nb_tkeep;
            tid_q <= from_nb_tid;
            tdest_q <= from_nb_tdest;
            tuser_q <= from_nb_tuser;
         end
         // Clear has priority over the in-order table update.
         if (i_table_clear) begin
            for (int unsigned i = 0; i < NUM_NODES; i++) table_q[i] <= '1;
         end else if (tbl_we) begin
            table_q[idx] <= seq_q;
         end
         if (inc_dup && cnt_dup_q != '1) cnt_dup_q <= cnt_dup_q + CNT_WIDTH'(1);
         if (inc_gap && cnt_gap_q != '1) cnt_gap_q <= cnt_gap_q + CNT_WIDTH'(1);
         if (inc_bad && cnt_bad_q != '1) cnt_bad_q <= cnt_bad_q + CNT_WIDTH'(1);
      end
   end

   always_comb begin
      to_ctrl_tdata = '0;
      to_ctrl_tdata[DATA_WIDTH-1:0] = payload_q;
      to_nb_KIP_tdata = '0;
      to_nb_KIP_tdata[MSG_TYPE_WIDTH-1:0] = rtype_q;
      to_nb_KIP_tdata[NODE_ID_OFFSET +: NODE_ID_WIDTH] = i_node_id;
      to_nb_KIP_tdata[SEQ_OFFSET +: SEQ_WIDTH] = rseq_q;
   end

   assign from_nb_tready   = (state_q == S_IDLE);
   assign to_ctrl_tvalid   = ctrl_v_q;
   assign to_ctrl_tlast    = 1'b1;
   assign to_ctrl_tkeep    = tkeep_q;
   assign to_ctrl_tid      = tid_q;
   assign to_ctrl_tdest    = tdest_q;
   assign to_ctrl_tuser    = tuser_q;
   assign to_nb_KIP_tvalid = kip_v_q;
   assign to_nb_KIP_tlast  = 1'b1;
   assign to_nb_KIP_tkeep  = '1;
   assign to_nb_KIP_tuser  = {i_KIP_port_number, i_KIP_port_number, tuser_q[31:0]};
   assign o_cnt_dup        = cnt_dup_q;
   assign o_cnt_gap        = cnt_gap_q;
   assign o_cnt_bad        = cnt_bad_q;

   assign unused_ok = ^{from_nb_tlast, from_nb_tdata};

endmodule

// File: tb/tb_rpn_lan_rx_window.sv
// Testbench for rpn_lan_rx_window: scoreboard of expected ctrl beats and KIP
// replies, filled by a reference sequence-table model at send time and drained
// by a monitor on each output handshake.
module tb_rpn_lan_rx_window;

   localparam int NIDW = 5;
   localparam logic [NIDW-1:0] MY_ID = 5'd9;
   localparam logic [15:0] PORT = 16'h1234;

   typedef struct packed {
      logic [511:0] data;
      logic [63:0]  keep;
      logic [7:0]   tid;
      logic [7:0]   tdest;
      logic [31:0]  tuser;
   } ctrl_t;

   typedef struct packed {
      logic [511:0] data;
      logic [63:0]  tuser;
   } kip_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic tbl_clr = 1'b0;
   logic nb_v = 1'b0, nb_r, nb_l = 1'b1;
   logic [511:0] nb_d = '0;
   logic [63:0] nb_k = '0;
   logic [7:0] nb_id = '0, nb_dst = '0;
   logic [31:0] nb_u = '0;
   logic c_v, c_r = 1'b1, c_l;
   logic [511:0] c_d;
   logic [63:0] c_k;
   logic [7:0] c_id, c_dst;
   logic [31:0] c_u;
   logic k_v, k_r = 1'b1, k_l;
   logic [511:0] k_d;
   logic [63:0] k_k, k_u;
   logic [15:0] cnt_dup, cnt_gap, cnt_bad;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int n_ctrl_beats = 0;
   logic [15:0] last_kip_seq = '0;

   ctrl_t ctrl_q[$];
   kip_t kip_q[$];
   ctrl_t c_exp;
   kip_t k_exp;
   logic [15:0] mtab [16];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rpn_lan_rx_window #(.NODE_ID_WIDTH(NIDW)) dut (
      .i_clk(clk), .i_ap_rst_n(rst_n), .i_node_id(MY_ID),
      .i_KIP_port_number(PORT), .i_table_clear(tbl_clr),
      .from_nb_tvalid(nb_v), .from_nb_tready(nb_r), .from_nb_tlast(nb_l),
      .from_nb_tdata(nb_d), .from_nb_tkeep(nb_k), .from_nb_tid(nb_id),
      .from_nb_tdest(nb_dst), .from_nb_tuser(nb_u),
      .to_ctrl_tvalid(c_v), .to_ctrl_tready(c_r), .to_ctrl_tlast(c_l),
      .to_ctrl_tdata(c_d), .to_ctrl_tkeep(c_k), .to_ctrl_tid(c_id),
      .to_ctrl_tdest(c_dst), .to_ctrl_tuser(c_u),
      .to_nb_KIP_tvalid(k_v), .to_nb_KIP_tready(k_r), .to_nb_KIP_tlast(k_l),
      .to_nb_KIP_tdata(k_d), .to_nb_KIP_tkeep(k_k), .to_nb_KIP_tuser(k_u),
      .o_cnt_dup(cnt_dup), .o_cnt_gap(cnt_gap), .o_cnt_bad(cnt_bad)
   );

   function automatic kip_t mk_kip(input logic [7:0] t, input logic [15:0] s, input logic [31:0] ip);
      kip_t k;
      k.data = '0;
      k.data[7:0] = t;
      k.data[12:8] = MY_ID;
      k.data[31:16] = s;
      k.tuser = {PORT, PORT, ip};
      return k;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mtab[i] = 16'hFFFF;
   endtask

   // Scoreboard: compare every output handshake against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         if (c_v && c_r) begin
            n_cmp++;
            n_ctrl_beats++;
            if (ctrl_q.size() == 0) begin
               n_err++;
               $display("FAIL ctrl_unexpected: got beat tdata[63:0]=%h, none expected", c_d[63:0]);
            end else begin
               c_exp = ctrl_q.pop_front();
               if ({c_d, c_k, c_id, c_dst, c_u} !== c_exp || c_l !== 1'b1) begin
                  n_err++;
                  $display("FAIL ctrl_beat: got data[319:0]=%h tid=%h tuser=%h, want data[319:0]=%h tid=%h tuser=%h",
                           c_d[319:0], c_id, c_u, c_exp.data[319:0], c_exp.tid, c_exp.tuser);
               end
            end
         end
         if (k_v && k_r) begin
            n_cmp++;
            last_kip_seq = k_d[31:16];
            if (kip_q.size() == 0) begin
               n_err++;
               $display("FAIL kip_unexpected: got tdata[31:0]=%h, none expected", k_d[31:0]);
            end else begin
               k_exp = kip_q.pop_front();
               if ({k_d, k_u} !== k_exp) begin
                  n_err++;
                  $display("FAIL kip_reply: got tdata[31:0]=%h tuser=%h, want tdata[31:0]=%h tuser=%h",
                           k_d[31:0], k_u, k_exp.data[31:0], k_exp.tuser);
               end
            end
         end
      end
   end

   // Drives one message (caller is just after a posedge), records expectations,
   // returns after the accepting edge.
   task automatic send(input logic [7:0] t, input logic [NIDW-1:0] id, input logic [15:0] s,
                       output int acc, output logic [255:0] pl);
      logic [15:0] ex;
      logic [3:0] ix;
      ctrl_t c;
      pl = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      nb_d = '0;
      nb_d[511:320] = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      nb_d[63:32] = $urandom();
      nb_d[7:0] = t;
      nb_d[12:8] = id;
      nb_d[31:16] = s;
      nb_d[319:64] = pl;
      nb_k = {$urandom(), $urandom()};
      nb_id = 8'($urandom());
      nb_dst = 8'($urandom());
      nb_u = $urandom();
      ix = id[3:0];
      if (id >= 16) begin
      end else if (t == 8'd3) begin
         kip_q.push_back(mk_kip(8'd4, mtab[ix], nb_u));
      end else if (t == 8'd1) begin
         ex = mtab[ix] + 16'd1;
         if (s == ex) begin
            mtab[ix] = s;
            kip_q.push_back(mk_kip(8'd2, s, nb_u));
            c.data = {256'b0, pl};
            c.keep = nb_k;
            c.tid = nb_id;
            c.tdest = nb_dst;
            c.tuser = nb_u;
            ctrl_q.push_back(c);
         end else if (s == mtab[ix]) begin
            kip_q.push_back(mk_kip(8'd2, s, nb_u));
         end else begin
            kip_q.push_back(mk_kip(8'd5, ex, nb_u));
         end
      end
      nb_v = 1'b1;
      acc = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (nb_r) begin
            @(posedge clk);
            #1;
            acc = cyc;
            break;
         end
      end
      nb_v = 1'b0;
      if (acc < 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL rx_accept: got no tready within 50 cycles, want accept");
      end
   endtask

   task automatic drain(input string tag);
      bit done = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (ctrl_q.size() == 0 && kip_q.size() == 0 && nb_r === 1'b1 && !c_v && !k_v) begin
            done = 1;
            break;
         end
      end
      n_cmp++;
      if (!done) begin
         n_err++;
         $display("FAIL drain_%s: got ctrl_q=%0d kip_q=%0d tready=%b, want all empty and idle",
                  tag, ctrl_q.size(), kip_q.size(), nb_r);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({c_v, k_v} !== 2'b00) begin
         n_err++;
         $display("FAIL reset_valids: got ctrl=%b kip=%b, want 0 0", c_v, k_v);
      end
      n_cmp++;
      if ({cnt_dup, cnt_gap, cnt_bad} !== 48'd0) begin
         n_err++;
         $display("FAIL reset_counters: got %0d %0d %0d, want 0 0 0", cnt_dup, cnt_gap, cnt_bad);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (nb_r !== 1'b1) begin
         n_err++;
         $display("FAIL reset_rx_ready: got %b, want 1", nb_r);
      end
      n_cmp++;
      if (k_k !== {64{1'b1}} || k_l !== 1'b1 || c_l !== 1'b1) begin
         n_err++;
         $display("FAIL reset_tied: got kip_tkeep=%h kip_tlast=%b ctrl_tlast=%b, want all-ones 1 1", k_k, k_l, c_l);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_first_data();
      int acc;
      logic [255:0] pl;
      c_r = 1'b1;
      k_r = 1'b1;
      send(8'd1, 5'd2, 16'd0, acc, pl);
      @(negedge clk);
      n_cmp++;
      if ({c_v, k_v} !== 2'b00) begin
         n_err++;
         $display("FAIL latency_early: got ctrl=%b kip=%b one cycle after accept, want 0 0", c_v, k_v);
      end
      @(negedge clk);
      n_cmp++;
      if ({c_v, k_v} !== 2'b11) begin
         n_err++;
         $display("FAIL latency_valid: got ctrl=%b kip=%b two cycles after accept, want 1 1", c_v, k_v);
      end
      @(negedge clk);
      n_cmp++;
      if (nb_r !== 1'b1 || {c_v, k_v} !== 2'b00) begin
         n_err++;
         $display("FAIL joint_handshake_idle: got tready=%b ctrl=%b kip=%b, want 1 0 0", nb_r, c_v, k_v);
      end
      drain("first");
      send(8'd3, 5'd2, 16'd0, acc, pl);
      drain("first_check");
      n_cmp++;
      if (last_kip_seq !== 16'h0000) begin
         n_err++;
         $display("FAIL first_table: got SEQ_REPLY seq=%h, want 0000", last_kip_seq);
      end
   endtask

   task automatic test_duplicate();
      int acc, beats;
      logic [255:0] pl;
      beats = n_ctrl_beats;
      send(8'd1, 5'd2, 16'd0, acc, pl);
      drain("dup");
      n_cmp++;
      if (cnt_dup !== 16'd1 || n_ctrl_beats != beats) begin
         n_err++;
         $display("FAIL duplicate: got cnt_dup=%0d new_ctrl_beats=%0d, want 1 0", cnt_dup, n_ctrl_beats - beats);
      end
   endtask

   task automatic test_gap();
      int acc;
      logic [255:0] pl;
      send(8'd1, 5'd2, 16'd5, acc, pl);
      drain("gap");
      n_cmp++;
      if (cnt_gap !== 16'd1 || last_kip_seq !== 16'd1) begin
         n_err++;
         $display("FAIL gap_nack: got cnt_gap=%0d nack_seq=%h, want 1 0001", cnt_gap, last_kip_seq);
      end
      send(8'd3, 5'd2, 16'd0, acc, pl);
      drain("gap_check");
      n_cmp++;
      if (last_kip_seq !== 16'h0000) begin
         n_err++;
         $display("FAIL gap_table: got SEQ_REPLY seq=%h, want 0000", last_kip_seq);
      end
   endtask

   task automatic test_wrap();
      int acc, beats;
      logic [255:0] pl;
      beats = n_ctrl_beats;
      send(8'd1, 5'd3, 16'd0, acc, pl);
      drain("wrap");
      n_cmp++;
      if (n_ctrl_beats != beats + 1) begin
         n_err++;
         $display("FAIL wrap_deliver: got %0d ctrl beats, want 1", n_ctrl_beats - beats);
      end
      send(8'd3, 5'd3, 16'd0, acc, pl);
      drain("wrap_check");
      n_cmp++;
      if (last_kip_seq !== 16'h0000) begin
         n_err++;
         $display("FAIL wrap_table: got SEQ_REPLY seq=%h, want 0000", last_kip_seq);
      end
   endtask

   task automatic test_ctrl_stall();
      int acc;
      logic [255:0] pl;
      c_r = 1'b0;
      k_r = 1'b1;
      send(8'd1, 5'd2, 16'd1, acc, pl);
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if ({c_v, k_v} !== 2'b11) begin
         n_err++;
         $display("FAIL stall_start: got ctrl=%b kip=%b, want 1 1", c_v, k_v);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if (c_v !== 1'b1 || k_v !== 1'b0 || nb_r !== 1'b0 || c_d !== {256'b0, pl}) begin
            n_err++;
            $display("FAIL stall_hold%0d: got ctrl=%b kip=%b tready=%b payload_ok=%b, want 1 0 0 1",
                     i, c_v, k_v, nb_r, c_d === {256'b0, pl});
         end
      end
      @(posedge clk);
      #1;
      c_r = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (c_v !== 1'b0 || nb_r !== 1'b1) begin
         n_err++;
         $display("FAIL stall_release: got ctrl=%b tready=%b, want 0 1", c_v, nb_r);
      end
      drain("stall");
   endtask

   task automatic test_back_to_back();
      int a0, a1, a2;
      logic [255:0] pl;
      send(8'd1, 5'd4, 16'd0, a0, pl);
      send(8'd1, 5'd4, 16'd1, a1, pl);
      send(8'd1, 5'd4, 16'd2, a2, pl);
      n_cmp++;
      if (a1 - a0 != 3 || a2 - a1 != 3) begin
         n_err++;
         $display("FAIL b2b_period: got %0d and %0d cycles, want 3 and 3", a1 - a0, a2 - a1);
      end
      drain("b2b");
   endtask

   task automatic test_bad_and_clear();
      int acc;
      logic [255:0] pl;
      send(8'd1, 5'd20, 16'd0, acc, pl);
      send(8'd9, 5'd2, 16'd2, acc, pl);
      drain("bad");
      n_cmp++;
      if (cnt_bad !== 16'd2) begin
         n_err++;
         $display("FAIL bad_count: got %0d, want 2", cnt_bad);
      end
      tbl_clr = 1'b1;
      @(posedge clk);
      #1;
      tbl_clr = 1'b0;
      model_reset();
      send(8'd3, 5'd2, 16'd0, acc, pl);
      drain("clear_check");
      n_cmp++;
      if (last_kip_seq !== 16'hFFFF) begin
         n_err++;
         $display("FAIL clear_table: got SEQ_REPLY seq=%h, want ffff", last_kip_seq);
      end
   endtask

   task automatic test_clear_vs_write();
      int acc, beats;
      logic [255:0] pl;
      beats = n_ctrl_beats;
      send(8'd1, 5'd5, 16'd0, acc, pl);
      tbl_clr = 1'b1;
      @(posedge clk);
      #1;
      tbl_clr = 1'b0;
      model_reset();
      drain("clear_write");
      n_cmp++;
      if (n_ctrl_beats != beats + 1) begin
         n_err++;
         $display("FAIL clear_no_abort: got %0d ctrl beats, want 1", n_ctrl_beats - beats);
      end
      send(8'd3, 5'd5, 16'd0, acc, pl);
      drain("clear_write_check");
      n_cmp++;
      if (last_kip_seq !== 16'hFFFF) begin
         n_err++;
         $display("FAIL clear_wins: got SEQ_REPLY seq=%h, want ffff", last_kip_seq);
      end
   endtask

   task automatic test_reset_mid();
      int acc;
      logic [255:0] pl;
      c_r = 1'b0;
      send(8'd1, 5'd2, 16'd0, acc, pl);
      @(negedge clk);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({c_v, k_v, nb_r} !== 3'b001 || {cnt_dup, cnt_gap, cnt_bad} !== 48'd0) begin
         n_err++;
         $display("FAIL reset_mid: got ctrl=%b kip=%b tready=%b cnts=%0d/%0d/%0d, want 0 0 1 0/0/0",
                  c_v, k_v, nb_r, cnt_dup, cnt_gap, cnt_bad);
      end
      ctrl_q.delete();
      kip_q.delete();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      c_r = 1'b1;
      @(posedge clk);
      #1;
      send(8'd3, 5'd2, 16'd0, acc, pl);
      drain("reset_mid_check");
      n_cmp++;
      if (last_kip_seq !== 16'hFFFF) begin
         n_err++;
         $display("FAIL reset_mid_table: got SEQ_REPLY seq=%h, want ffff", last_kip_seq);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_first_data();
      test_duplicate();
      test_gap();
      test_wrap();
      test_ctrl_stall();
      test_back_to_back();
      test_bad_and_clear();
      test_clear_vs_write();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
